dpram_ctrl: RTL and testbench

DPRAM_CTRL -- requirements
Module: dpram_ctrl

---
 rtl/dpram_ctrl.sv | 119 +++++++++++
 tb/tb_dpram_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_ctrl.sv
// Dual-port RAM access controller: clears the RAM after reset, then gives each
// requester its own RAM port and arbitrates same-address conflicts round-robin.
module dpram_ctrl #(
    parameter int DW = 8,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_a,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          rvalid_a,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    output logic          busy,
    output logic [7:0]    conflict_cnt,
    output logic [AW-1:0] ram_ad_a,
    output logic [AW-1:0] ram_ad_b,
    output logic [DW-1:0] ram_data_a,
    output logic [DW-1:0] ram_data_b,
    output logic          ram_wre_a,
    output logic          ram_wre_b,
    input  logic [DW-1:0] ram_q_a,
    input  logic [DW-1:0] ram_q_b
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] clr_cnt;
    logic [AW-1:0] ad_a_q, ad_b_q;
    logic [DW-1:0] data_a_q, data_b_q;
    logic          prio;       // 0: A wins the next conflict, 1: B wins
    logic          conflict;

    assign rdata_a = ram_q_a;
    assign rdata_b = ram_q_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= CLEAR;
            clr_cnt      <= '0;
            prio         <= 1'b0;
            conflict_cnt <= 8'd0;
            rvalid_a     <= 1'b0;
            rvalid_b     <= 1'b0;
            ad_a_q       <= '0;
            ad_b_q       <= '0;
            data_a_q     <= '0;
            data_b_q     <= '0;
        end else begin
            state    <= state_nxt;
            rvalid_a <= gnt_a & ~we_a;
            rvalid_b <= gnt_b & ~we_b;
            // Ungranted ports keep presenting the last address/data they drove.
            ad_a_q   <= ram_ad_a;
            ad_b_q   <= ram_ad_b;
            data_a_q <= ram_data_a;
            data_b_q <= ram_data_b;
            if (state == CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
            if (conflict) begin
                prio <= ~prio;
                if (conflict_cnt != 8'hFF)
                    conflict_cnt <= conflict_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        gnt_a      = 1'b0;
        gnt_b      = 1'b0;
        busy       = 1'b0;
        conflict   = 1'b0;
        ram_wre_a  = 1'b0;
        ram_wre_b  = 1'b0;
        ram_ad_a   = ad_a_q;
        ram_ad_b   = ad_b_q;
        ram_data_a = data_a_q;
        ram_data_b = data_b_q;
        case (state)
            CLEAR: begin
                busy       = 1'b1;
                // Gate with rst so the write strobe drops the instant reset asserts.
                ram_wre_a  = ~rst;
                ram_ad_a   = clr_cnt;
                ram_data_a = '0;
                if (clr_cnt == '1)
                    state_nxt = RUN;
            end
            RUN: begin
                conflict = req_a & req_b & (addr_a == addr_b) & (we_a | we_b);
                gnt_a    = req_a & (~conflict | ~prio);
                gnt_b    = req_b & (~conflict | prio);
                if (gnt_a) begin
                    ram_wre_a  = we_a;
                    ram_ad_a   = addr_a;
                    ram_data_a = wdata_a;
                end
                if (gnt_b) begin
                    ram_wre_b  = we_b;
                    ram_ad_b   = addr_b;
                    ram_data_b = wdata_b;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

endmodule

// File: tb/tb_dpram_ctrl.sv
// Self-checking bench for dpram_ctrl: behavioural RAM, reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_dpram_ctrl;

    logic       clk, rst;
    logic       req_a, req_b, we_a, we_b;
    logic [5:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b, busy;
    logic [7:0] rdata_a, rdata_b, conflict_cnt;
    logic [5:0] ram_ad_a, ram_ad_b;
    logic [7:0] ram_data_a, ram_data_b;
    logic       ram_wre_a, ram_wre_b;
    logic [7:0] ram_q_a, ram_q_b;

    int checks = 0;
    int failures = 0;

    dpram_ctrl #(.DW(8), .AW(6)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy), .conflict_cnt(conflict_cnt),
        .ram_ad_a(ram_ad_a), .ram_ad_b(ram_ad_b),
        .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
        .ram_wre_a(ram_wre_a), .ram_wre_b(ram_wre_b),
        .ram_q_a(ram_q_a), .ram_q_b(ram_q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port synchronous RAM, filled with garbage so the clear sweep matters.
    logic [7:0] ram [64];
    initial for (int i = 0; i < 64; i++) ram[i] = 8'($urandom);
    always @(posedge clk) begin
        if (ram_wre_a) ram[ram_ad_a] <= ram_data_a;
        if (ram_wre_b) ram[ram_ad_b] <= ram_data_b;
        ram_q_a <= ram[ram_ad_a];
        ram_q_b <= ram[ram_ad_b];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: memory contents, sweep progress, priority, counter, pending reads.
    logic [7:0] m_mem [64];
    bit         m_run, m_prio, m_rv_a, m_rv_b;
    int         m_clr, m_cnt;
    logic [7:0] m_rd_a, m_rd_b, m_d_a, m_d_b;
    logic [5:0] m_ad_a, m_ad_b;

    function automatic bit clash();
        return req_a && req_b && (addr_a == addr_b) && (we_a || we_b);
    endfunction

    function automatic void arbitrate(output bit ga, output bit gb);
        ga = 0;
        gb = 0;
        if (rst || !m_run) return;
        if (!clash()) begin
            ga = req_a;
            gb = req_b;
        end else if (!m_prio) ga = 1;
        else gb = 1;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit ga, gb;
        if (rst) begin
            m_run = 0; m_clr = 0; m_prio = 0; m_cnt = 0;
            m_rv_a = 0; m_rv_b = 0;
            m_ad_a = 0; m_ad_b = 0; m_d_a = 0; m_d_b = 0;
        end else begin
            arbitrate(ga, gb);
            m_rv_a = ga && !we_a;
            m_rv_b = gb && !we_b;
            m_rd_a = m_mem[addr_a];
            m_rd_b = m_mem[addr_b];
            if (!m_run) begin
                m_mem[m_clr] = 8'h00;
                m_ad_a = 6'(m_clr);
                m_d_a  = 8'h00;
                if (m_clr == 63) m_run = 1;
                else m_clr++;
            end else begin
                if (clash()) begin
                    m_prio = !m_prio;
                    if (m_cnt < 255) m_cnt++;
                end
                if (ga) begin
                    if (we_a) m_mem[addr_a] = wdata_a;
                    m_ad_a = addr_a; m_d_a = wdata_a;
                end
                if (gb) begin
                    if (we_b) m_mem[addr_b] = wdata_b;
                    m_ad_b = addr_b; m_d_b = wdata_b;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        bit ga, gb;
        arbitrate(ga, gb);
        chk("busy", 32'(busy), 32'(rst || !m_run));
        chk("gnt_a", 32'(gnt_a), 32'(ga));
        chk("gnt_b", 32'(gnt_b), 32'(gb));
        chk("ram_wre_a", 32'(ram_wre_a), 32'(!rst && (!m_run || (ga && we_a))));
        chk("ram_wre_b", 32'(ram_wre_b), 32'(gb && we_b));
        chk("ram_ad_a", 32'(ram_ad_a), !m_run ? 32'(m_clr) : ga ? 32'(addr_a) : 32'(m_ad_a));
        chk("ram_ad_b", 32'(ram_ad_b), gb ? 32'(addr_b) : 32'(m_ad_b));
        chk("ram_data_a", 32'(ram_data_a), !m_run ? 32'(0) : ga ? 32'(wdata_a) : 32'(m_d_a));
        chk("ram_data_b", 32'(ram_data_b), gb ? 32'(wdata_b) : 32'(m_d_b));
        chk("rvalid_a", 32'(rvalid_a), 32'(m_rv_a));
        chk("rvalid_b", 32'(rvalid_b), 32'(m_rv_b));
        if (m_rv_a) chk("rdata_a", 32'(rdata_a), 32'(m_rd_a));
        if (m_rv_b) chk("rdata_b", 32'(rdata_b), 32'(m_rd_b));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    end

    task automatic set_a(input logic r, input logic w, input logic [5:0] ad, input logic [7:0] d);
        req_a = r; we_a = w; addr_a = ad; wdata_a = d;
    endtask

    task automatic set_b(input logic r, input logic w, input logic [5:0] ad, input logic [7:0] d);
        req_b = r; we_b = w; addr_b = ad; wdata_b = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts sweep cycles after a reset release; bounded so a stuck busy cannot hang.
    task automatic sweep(input string name);
        int n = 0;
        @(negedge clk);
        chk({name, "_first_ad"}, 32'(ram_ad_a), 32'h0);
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_len"}, 32'(n), 32'd64);
        tick();
    endtask

    task automatic run_random(input int n);
        bit pa = 0, pb = 0;
        for (int i = 0; i < n; i++) begin
            if (!pa) begin
                if ($urandom_range(0, 9) < 6)
                    set_a(1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 3)), 8'($urandom));
                else set_a(0, 0, 0, 0);
                pa = req_a;
            end
            if (!pb) begin
                if ($urandom_range(0, 9) < 6)
                    set_b(1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 3)), 8'($urandom));
                else set_b(0, 0, 0, 0);
                pb = req_b;
            end
            @(negedge clk);
            if (gnt_a) pa = 0;
            if (gnt_b) pb = 0;
            tick();
        end
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
    endtask

    initial begin : stim
        int a_wins;
        rst = 1'b1;
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        sweep("sweep1");

        // read of a cleared location
        set_a(1, 0, 6'h05, 8'h00);
        @(negedge clk); chk("rd05_gnt", 32'(gnt_a), 32'd1);
        tick(); set_a(0, 0, 0, 0);
        @(negedge clk); chk("rd05_rvalid", 32'(rvalid_a), 32'd1);
        chk("rd05_data", 32'(rdata_a), 32'h00);
        tick();

        // different-address writes, then crossed reads
        set_a(1, 1, 6'h02, 8'h22); set_b(1, 1, 6'h01, 8'h34);
        @(negedge clk); chk("dual_wr_gnt", 32'({gnt_a, gnt_b}), 32'b11);
        chk("dual_wr_cnt", 32'(conflict_cnt), 32'd0);
        tick();
        set_a(1, 0, 6'h01, 8'h00); set_b(1, 0, 6'h02, 8'h00);
        tick(); set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
        @(negedge clk); chk("cross_rd_a", 32'(rdata_a), 32'h34);
        chk("cross_rd_b", 32'(rdata_b), 32'h22);
        tick();

        // write/write conflict with priority at A
        set_a(1, 1, 6'h03, 8'h45); set_b(1, 1, 6'h03, 8'h77);
        @(negedge clk); chk("ww_gnt", 32'({gnt_a, gnt_b}), 32'b10);
        tick(); set_a(0, 0, 0, 0);
        @(negedge clk); chk("ww_cnt", 32'(conflict_cnt), 32'd1);
        chk("ww_gnt_b_next", 32'(gnt_b), 32'd1);
        tick(); set_b(0, 0, 0, 0);
        set_a(1, 0, 6'h03, 8'h00);
        tick(); set_a(0, 0, 0, 0);
        @(negedge clk); chk("ww_rd03", 32'(rdata_a), 32'h77);
        tick();

        // read/write conflict: priority now at B
        set_a(1, 0, 6'h03, 8'h00); set_b(1, 1, 6'h03, 8'h5A);
        @(negedge clk); chk("rw_gnt", 32'({gnt_a, gnt_b}), 32'b01);
        tick(); set_b(0, 0, 0, 0);
        @(negedge clk); chk("rw_gnt_a_next", 32'(gnt_a), 32'd1);
        tick(); set_a(0, 0, 0, 0);
        @(negedge clk); chk("rw_rvalid", 32'(rvalid_a), 32'd1);
        chk("rw_rdata", 32'(rdata_a), 32'h5A);
        chk("rw_cnt", 32'(conflict_cnt), 32'd2);
        tick();

        // 300 back-to-back conflicts: counter saturates, winners alternate
        a_wins = 0;
        for (int i = 0; i < 300; i++) begin
            set_a(1, 1, 6'h09, 8'(i)); set_b(1, 1, 6'h09, 8'(~i));
            @(negedge clk);
            if (gnt_a) a_wins++;
            tick();
        end
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
        @(negedge clk); chk("sat_cnt", 32'(conflict_cnt), 32'd255);
        chk("sat_a_wins", 32'(a_wins), 32'd150);
        tick();

        run_random(1500);
        tick();

        // async reset while a read is granted
        set_a(1, 0, 6'h07, 8'h00);
        @(negedge clk); chk("arst_gnt_before", 32'(gnt_a), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_gnt_a", 32'(gnt_a), 32'd0);
        chk("arst_busy", 32'(busy), 32'd1);
        chk("arst_wre_a", 32'(ram_wre_a), 32'd0);
        chk("arst_ad_a", 32'(ram_ad_a), 32'd0);
        chk("arst_ad_b", 32'(ram_ad_b), 32'd0);
        chk("arst_cnt", 32'(conflict_cnt), 32'd0);
        set_a(0, 0, 0, 0);
        tick();
        chk("arst_rvalid", 32'({rvalid_a, rvalid_b}), 32'd0);
        rst = 1'b0;
        sweep("sweep2");

        run_random(500);
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
